// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// FSM state encodings and the default operand width.
package shift_add_mult_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result valid-ready bundle for the shift-add multiplier.
// master = operand producer / result consumer, slave = multiplier controller.
interface shift_add_mult_ctrl_if
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 result_valid;
  logic                 result_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output start_valid, multiplicand, multiplier, result_ready,
    input  start_ready, result_valid, product, busy
  );

  modport slave (
    input  start_valid, multiplicand, multiplier, result_ready,
    output start_ready, result_valid, product, busy
  );

endinterface

// File: rtl/shift_add_mult_ctrl_adder.sv
// Plain ripple-carry adder; the multiplier reuses one instance every step.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] carry_chain;

  assign carry_chain[0] = carry_i;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum_o[gi]          = a_i[gi] ^ b_i[gi] ^ carry_chain[gi];
      assign carry_chain[gi+1]  = (a_i[gi] & b_i[gi]) | (carry_chain[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign carry_o = carry_chain[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: one adder time-multiplexed over
// WIDTH steps, product = {acc, mq}, valid/ready on operands and result.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  shift_add_mult_ctrl_if.slave      bus
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      count_q;
  logic               start_ready_q;
  logic               result_valid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mq_d;

  assign addend = mq_q[0] ? mcand_q : '0;

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i     (acc_q),
    .b_i     (addend),
    .carry_i (1'b0),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // The adder carry becomes the new acc MSB; the sum LSB shifts into mq.
  assign acc_d = {carry, sum[WIDTH-1:1]};
  assign mq_d  = {sum[0], mq_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      mq_q           <= '0;
      mcand_q        <= '0;
      count_q        <= '0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_valid) begin
            mcand_q       <= bus.multiplicand;
            mq_q          <= bus.multiplier;
            acc_q         <= '0;
            count_q       <= '0;
            state_q       <= ST_CALC;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_q   <= acc_d;
          mq_q    <= mq_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_q        <= ST_DONE;
            result_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            start_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          start_ready_q  <= 1'b1;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.product      = {acc_q, mq_q};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Randomized self-checking bench for shift_add_mult_ctrl (WIDTH=4) against
// a queue-based A*B reference model.
module tb_shift_add_mult_ctrl;

  localparam int WIDTH = 4;
  localparam int LATENCY = WIDTH;

  logic clk;
  logic rst_n;

  shift_add_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_add_mult_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int n_txn;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int a, input int b, input int stalls, input bit poke);
    int cycles;
    int expected;
    logic [2*WIDTH-1:0] held;
    cycles = 0;
    while (!bus.start_ready && cycles < 20) begin
      tick();
      cycles++;
    end
    check("start_ready_wait", bus.start_ready, 1);
    bus.multiplicand = a[WIDTH-1:0];
    bus.multiplier   = b[WIDTH-1:0];
    bus.start_valid  = 1'b1;
    exp_q.push_back(a * b);
    tick();
    bus.start_valid  = 1'b0;
    // Operands are free to change once accepted.
    bus.multiplicand = WIDTH'($urandom);
    bus.multiplier   = WIDTH'($urandom);
    check("busy_calc", bus.busy, 1);
    check("start_ready_calc", bus.start_ready, 0);
    if (poke) begin
      bus.start_valid = 1'b1;
    end
    cycles = 0;
    while (!bus.result_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("latency", cycles, LATENCY);
    held = bus.product;
    for (int s = 0; s < stalls; s++) begin
      tick();
      check("stall_product", bus.product, held);
      check("stall_valid", bus.result_valid, 1);
      check("stall_start_ready", bus.start_ready, 0);
    end
    bus.start_valid = 1'b0;
    expected = exp_q.pop_front();
    check("product", bus.product, expected);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("accept_valid_low", bus.result_valid, 0);
    check("accept_start_ready", bus.start_ready, 1);
    $display("txn %0d: A=%0d B=%0d stalls=%0d product=%0d", n_txn, a, b, stalls, held);
    n_txn++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_txn    = 0;
    rst_n            = 1'b0;
    bus.start_valid  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.result_ready = 1'b0;
    tick();
    tick();
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_product", bus.product, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    run_op(13, 11, 0, 1'b0);
    run_op(15, 15, 0, 1'b0);
    run_op(0, 9, 0, 1'b0);
    run_op(5, 3, 3, 1'b1);

    // Abort mid-calculation: reset at the second CALC cycle.
    bus.multiplicand = 4'd9;
    bus.multiplier   = 4'd7;
    bus.start_valid  = 1'b1;
    tick();
    bus.start_valid  = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_start_ready", bus.start_ready, 1);
    check("abort_result_valid", bus.result_valid, 0);
    check("abort_product", bus.product, 0);
    check("abort_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", bus.result_valid, 0);
    end
    $display("txn %0d: A=9 B=7 aborted by reset", n_txn);
    n_txn++;
    run_op(7, 6, 0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, int'($urandom_range(0, 2)), 1'(($urandom % 4) == 0));
      end
    end
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
